inta_sequencer: RTL and testbench

//   CPU-side initiator of the 8259A interrupt-acknowledge protocol; drives the PIC's INTA input.
//   - Watches the PIC INT line.
//   - Generates the two-pulse active-low INTA sequence and captures the vector byte from the data bus.
//   - Hands the vector to the core over a valid/ready handshake.
//   - When the core signals service complete, writes an OCW2 EOI command, unless AEOI is in use.

---
 rtl/inta_sequencer.sv | 148 ++++++++++++++
 tb/tb_inta_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inta_sequencer.sv
// 8259A interrupt-acknowledge initiator: synchronises INT, issues the two INTA
// pulses, captures the vector, hands it to the core and issues the OCW2 EOI.
module inta_sequencer #(
    parameter int PULSE_W  = 2,
    parameter int GAP_W    = 2,
    parameter bit EOI_SPEC = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_i,
    input  logic       int_en,
    input  logic       aeoi,
    input  logic [7:0] data_in,
    output logic       inta_n,
    output logic       vec_valid,
    output logic [7:0] vec_out,
    input  logic       vec_ready,
    input  logic       svc_done,
    output logic       eoi_wr,
    output logic [7:0] eoi_data,
    output logic       busy
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W) + 1;
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK1    = 3'd1,
        GAP     = 3'd2,
        ACK2    = 3'd3,
        DELIVER = 3'd4,
        SERVICE = 3'd5,
        EOI     = 3'd6
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          int_meta_reg, int_s_reg;

    logic       inta_n_reg, inta_n_next;
    logic       vec_valid_reg, vec_valid_next;
    logic [7:0] vec_out_reg, vec_out_next;
    logic       eoi_wr_reg, eoi_wr_next;
    logic [7:0] eoi_data_reg, eoi_data_next;
    logic       busy_reg, busy_next;
    logic [7:0] eoi_byte;

    // Two-flop synchroniser; only int_s_reg is visible to the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_meta_reg <= 1'b0;
            int_s_reg    <= 1'b0;
        end else begin
            int_meta_reg <= int_i;
            int_s_reg    <= int_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter is reloaded on every timed-state entry and counts down to zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg != '0) ? cnt_reg - CW'(1) : cnt_reg;
        case (state_reg)
            IDLE: begin
                if (int_s_reg && int_en) begin
                    state_next = ACK1;
                    cnt_next   = PULSE_LD;
                end
            end
            ACK1: begin
                if (cnt_reg == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = ACK2;
                    cnt_next   = PULSE_LD;
                end
            end
            ACK2: begin
                if (cnt_reg == '0) state_next = DELIVER;
            end
            DELIVER: begin
                if (vec_ready) state_next = SERVICE;
            end
            SERVICE: begin
                if (svc_done) state_next = aeoi ? IDLE : EOI;
            end
            EOI:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign eoi_byte = EOI_SPEC ? {3'b011, 2'b00, vec_out_reg[2:0]} : 8'h20;

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state.
    always_comb begin
        inta_n_next    = !((state_next == ACK1) || (state_next == ACK2));
        vec_valid_next = (state_next == DELIVER);
        vec_out_next   = vec_out_reg;
        if ((state_reg == ACK2) && (cnt_reg == '0)) vec_out_next = data_in;
        eoi_wr_next    = (state_next == EOI);
        eoi_data_next  = (state_next == EOI) ? eoi_byte : 8'h00;
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inta_n_reg    <= 1'b1;
            vec_valid_reg <= 1'b0;
            vec_out_reg   <= 8'h00;
            eoi_wr_reg    <= 1'b0;
            eoi_data_reg  <= 8'h00;
            busy_reg      <= 1'b0;
        end else begin
            inta_n_reg    <= inta_n_next;
            vec_valid_reg <= vec_valid_next;
            vec_out_reg   <= vec_out_next;
            eoi_wr_reg    <= eoi_wr_next;
            eoi_data_reg  <= eoi_data_next;
            busy_reg      <= busy_next;
        end
    end

    assign inta_n    = inta_n_reg;
    assign vec_valid = vec_valid_reg;
    assign vec_out   = vec_out_reg;
    assign eoi_wr    = eoi_wr_reg;
    assign eoi_data  = eoi_data_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: a non-specific-EOI and a specific-EOI instance share
// stimulus; expected waveforms come from pulse/gap arithmetic and the EOI rules.
module tb_inta_sequencer;

    localparam int P = 2;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       reset, int_i, int_en, aeoi, vec_ready, svc_done;
    logic [7:0] data_in;
    logic       inta_n0, vec_valid0, eoi_wr0, busy0;
    logic [7:0] vec_out0, eoi_data0;
    logic       inta_n1, vec_valid1, eoi_wr1, busy1;
    logic [7:0] vec_out1, eoi_data1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inta_sequencer #(.PULSE_W(P), .GAP_W(G), .EOI_SPEC(1'b0)) dut0 (
        .clk(clk), .reset(reset), .int_i(int_i), .int_en(int_en), .aeoi(aeoi),
        .data_in(data_in), .inta_n(inta_n0), .vec_valid(vec_valid0), .vec_out(vec_out0),
        .vec_ready(vec_ready), .svc_done(svc_done), .eoi_wr(eoi_wr0), .eoi_data(eoi_data0),
        .busy(busy0)
    );

    inta_sequencer #(.PULSE_W(P), .GAP_W(G), .EOI_SPEC(1'b1)) dut1 (
        .clk(clk), .reset(reset), .int_i(int_i), .int_en(int_en), .aeoi(aeoi),
        .data_in(data_in), .inta_n(inta_n1), .vec_valid(vec_valid1), .vec_out(vec_out1),
        .vec_ready(vec_ready), .svc_done(svc_done), .eoi_wr(eoi_wr1), .eoi_data(eoi_data1),
        .busy(busy1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Cycle i counted from ACK1 entry: P low, G high, P low.
    function automatic logic exp_inta(input int i);
        return !((i < P) || ((i >= P + G) && (i < 2 * P + G)));
    endfunction

    function automatic logic [7:0] junk_for(input logic [7:0] vec);
        logic [7:0] j;
        j = 8'($urandom);
        if (j == vec) j = ~vec;
        return j;
    endfunction

    task automatic cleanup();
        reset = 1'b1; int_i = 1'b0; vec_ready = 1'b0; svc_done = 1'b0;
        step();
        reset = 1'b0;
        step();
        check_b("cleanup busy", busy0, 1'b0);
    endtask

    // One complete acknowledge transaction from int_i rising to return to IDLE.
    task automatic do_ack(input logic [7:0] vec, input int dly, input bit ae, input bit keep);
        logic [7:0] exp_spec;
        int         s;
        exp_spec = 8'h60 | {5'b00000, vec[2:0]};
        int_en = 1'b1; int_i = 1'b1; data_in = junk_for(vec);
        step(); check_b("sync1 inta_n", inta_n0, 1'b1);
        step(); check_b("sync2 inta_n", inta_n0, 1'b1);
        for (int i = 0; i < 2 * P + G; i++) begin
            step();
            check_b("inta_n", inta_n0, exp_inta(i));
            check_b("inta_n spec", inta_n1, exp_inta(i));
            check_b("ack busy", busy0, 1'b1);
            check_b("ack vec_valid", vec_valid0, 1'b0);
            if (!keep && i == 0) begin
                int_i  = 1'b0;
                int_en = 1'($urandom_range(0, 1));
            end
            data_in   = (i == 2 * P + G - 1) ? vec : junk_for(vec);
            vec_ready = (i == 2 * P + G - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            svc_done  = 1'($urandom_range(0, 1));
        end
        for (int k = 0; k <= dly; k++) begin
            step();
            check_b("deliver vec_valid", vec_valid0, 1'b1);
            check("deliver vec_out", vec_out0, vec);
            check_b("deliver inta_n", inta_n0, 1'b1);
            check_b("deliver eoi_wr", eoi_wr0, 1'b0);
            data_in   = junk_for(vec);
            vec_ready = (k == dly);
            svc_done  = 1'($urandom_range(0, 1));
        end
        step();
        vec_ready = 1'b0; svc_done = 1'b0;
        check_b("service vec_valid", vec_valid0, 1'b0);
        check("service vec_out hold", vec_out0, vec);
        check_b("service busy", busy0, 1'b1);
        s = int'($urandom_range(0, 3));
        for (int k = 0; k < s; k++) begin
            vec_ready = 1'($urandom_range(0, 1));
            step();
            check_b("service wait eoi_wr", eoi_wr0, 1'b0);
            check_b("service wait busy", busy0, 1'b1);
        end
        vec_ready = 1'b0; aeoi = ae; svc_done = 1'b1;
        step();
        svc_done = 1'b0; aeoi = 1'($urandom_range(0, 1));
        if (!ae) begin
            check_b("eoi_wr", eoi_wr0, 1'b1);
            check("eoi_data nonspec", eoi_data0, 8'h20);
            check_b("eoi_wr spec", eoi_wr1, 1'b1);
            check("eoi_data spec", eoi_data1, exp_spec);
            check_b("eoi busy", busy0, 1'b1);
            step();
            check_b("post eoi_wr", eoi_wr0, 1'b0);
            check_b("post eoi busy", busy0, 1'b0);
        end else begin
            check_b("aeoi no eoi_wr", eoi_wr0, 1'b0);
            check_b("aeoi no eoi_wr spec", eoi_wr1, 1'b0);
            check_b("aeoi busy", busy0, 1'b0);
        end
        check_b("idle inta_n", inta_n0, 1'b1);
        $display("txn vec=%h dly=%0d aeoi=%0d keep=%0d checks=%0d fails=%0d", vec, dly, ae, keep, n_checks, n_fail);
    endtask

    initial begin
        reset = 1'b1; int_i = 1'b0; int_en = 1'b0; aeoi = 1'b0;
        vec_ready = 1'b0; svc_done = 1'b0; data_in = 8'h00;
        step(); step();
        check_b("reset inta_n", inta_n0, 1'b1);
        check_b("reset vec_valid", vec_valid0, 1'b0);
        check("reset vec_out", vec_out0, 8'h00);
        check_b("reset eoi_wr", eoi_wr0, 1'b0);
        check("reset eoi_data", eoi_data1, 8'h00);
        check_b("reset busy", busy0, 1'b0);
        reset = 1'b0;
        step();

        do_ack(8'h4B, 0, 1'b0, 1'b0);
        do_ack(8'h45, 0, 1'b0, 1'b0);
        do_ack(8'h30, 0, 1'b1, 1'b0);
        do_ack(8'h97, 10, 1'b0, 1'b0);
        for (int n = 0; n < 12; n++)
            do_ack(8'($urandom), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'b0);

        // int_s still high on return to IDLE: one IDLE cycle, then ACK1.
        do_ack(8'($urandom), 1, 1'b1, 1'b1);
        step();
        check_b("retrigger inta_n", inta_n0, 1'b0);
        check_b("retrigger busy", busy0, 1'b1);
        cleanup();

        // int_i activity with int_en low must not start a sequence.
        int_en = 1'b0; int_i = 1'b1;
        step();
        int_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_b("masked pulse inta_n", inta_n0, 1'b1);
            check_b("masked pulse busy", busy0, 1'b0);
            int_i = (k >= 2);
        end
        int_i = 1'b0;
        step(); step(); step();
        $display("txn masked int_i checks=%0d fails=%0d", n_checks, n_fail);

        // Reset during the first ACK2 low cycle, then restart with int_i held high.
        int_en = 1'b1; int_i = 1'b1;
        step(); step();
        for (int i = 0; i <= P + G; i++) step();
        check_b("pre-reset ack2 inta_n", inta_n0, 1'b0);
        reset = 1'b1;
        step();
        check_b("midreset inta_n", inta_n0, 1'b1);
        check_b("midreset vec_valid", vec_valid0, 1'b0);
        check_b("midreset busy", busy0, 1'b0);
        check("midreset vec_out", vec_out0, 8'h00);
        reset = 1'b0;
        step(); check_b("restart edge1 inta_n", inta_n0, 1'b1);
        step(); check_b("restart edge2 inta_n", inta_n0, 1'b1);
        step(); check_b("restart ack1 inta_n", inta_n0, 1'b0);
        check_b("restart busy", busy0, 1'b1);
        cleanup();
        $display("txn reset mid-ACK2 checks=%0d fails=%0d", n_checks, n_fail);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
